// File: rtl/uart_pkg.sv
// Shared UART definitions: RX state encoding, parity selectors, legal
// oversampling rates and the three-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic prescale_legal(input logic [5:0] p);
        return !p[0] && (p >= PRESCALE_8) && (p <= PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter, bit counter and three-sample majority vote for the
// UART receiver.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             rx_in,
    input  logic [5:0]       prescale,
    input  logic             start,
    input  logic             active,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             sampled_bit,
    output logic             sample_valid,
    output logic             bit_wrap
);

    logic [5:0] edge_cnt;
    logic [5:0] half;
    logic       s0;
    logic       s1;

    assign half         = {1'b0, prescale[5:1]};
    assign bit_wrap     = active && (edge_cnt == prescale - 6'd1);
    assign sample_valid = active && (edge_cnt == half + 6'd1);
    // Third sample is taken straight from the line so the voted bit is
    // registered by the FSM on the same edge that would capture it.
    assign sampled_bit  = majority3(s0, s1, rx_in);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
        end else begin
            if (start) begin
                edge_cnt <= 6'd1;
                bit_cnt  <= '0;
            end else if (!active) begin
                edge_cnt <= '0;
                bit_cnt  <= '0;
            end else if (bit_wrap) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 1'b1;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end

            if (active && (edge_cnt == half - 6'd1))
                s0 <= rx_in;
            if (active && (edge_cnt == half))
                s1 <= rx_in;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first deserializer, parity/stop checks and
// registered one-cycle result pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 3);

    rx_state_e             state;
    logic [5:0]            prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_err_q;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  sampled_bit;
    logic                  sample_valid;
    logic                  bit_wrap;
    logic                  start;
    logic                  active;
    logic                  par_exp;

    assign start   = (state == IDLE) && !RX_IN;
    assign active  = (state != IDLE);
    assign par_exp = (par_typ_q == PAR_EVEN) ? ^shreg : ~^shreg;

    uart_rx_sampler #(
        .CNT_W(CNT_W)
    ) u_sampler (
        .CLK          (CLK),
        .RST          (RST),
        .rx_in        (RX_IN),
        .prescale     (prescale_q),
        .start        (start),
        .active       (active),
        .bit_cnt      (bit_cnt),
        .sampled_bit  (sampled_bit),
        .sample_valid (sample_valid),
        .bit_wrap     (bit_wrap)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            prescale_q <= PRESCALE_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            par_err_q  <= 1'b0;
            shreg      <= '0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        // An unsupported rate falls back to a safe one so the counters always wrap.
                        prescale_q <= prescale_legal(PRESCALE) ? PRESCALE : PRESCALE_16;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_err_q  <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (sample_valid && sampled_bit)
                        state <= IDLE;
                    else if (bit_wrap)
                        state <= DATA;
                end

                DATA: begin
                    if (sample_valid)
                        shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                    if (bit_wrap && (bit_cnt == CNT_W'(DATA_WIDTH)))
                        state <= par_en_q ? PARITY : STOP;
                end

                PARITY: begin
                    if (sample_valid)
                        par_err_q <= (sampled_bit != par_exp);
                    if (bit_wrap)
                        state <= STOP;
                end

                STOP: begin
                    if (sample_valid) begin
                        state <= IDLE;
                        if (sampled_bit && !par_err_q) begin
                            DATA_VALID <= 1'b1;
                            P_DATA     <= shreg;
                        end else begin
                            PAR_ERR <= par_err_q;
                            STP_ERR <= !sampled_bit;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, glitch, back-to-back
// and mid-frame reset sequences, then randomized frames against a frame model.
module tb_uart_rx;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
    } ev_t;
    ev_t evq[$];

    always @(negedge CLK)
        if (DATA_VALID || PAR_ERR || STP_ERR)
            evq.push_back('{cyc, DATA_VALID, PAR_ERR, STP_ERR, P_DATA});

    typedef struct {
        logic [7:0] d;
        int         p;
        bit         pen;
        bit         ptyp;
        bit         badpar;
        bit         stopv;
        bit         glitch;
        bit         dv;
        bit         pe;
        bit         se;
        int         rel;
    } vec_t;

    typedef struct {
        bit dv;
        bit pe;
        bit se;
        int rel;
    } exp_t;

    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: parity counted over data+parity bit ones.
    function automatic exp_t model(input logic [7:0] d, input int p, input bit pen,
                                   input bit ptyp, input bit parbit, input bit stopv);
        exp_t m;
        int   ones;
        int   nbits;
        ones  = $countones(d) + (pen ? int'(parbit) : 0);
        m.pe  = pen && ((ones % 2) != int'(ptyp));
        m.se  = !stopv;
        m.dv  = !m.pe && !m.se;
        nbits = 1 + 8 + (pen ? 1 : 0) + 1;
        m.rel = (nbits - 1) * p + p / 2 + 2;
        return m;
    endfunction

    function automatic bit good_parity(input logic [7:0] d, input bit ptyp);
        return bit'($countones(d) % 2) ^ ptyp;
    endfunction

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(posedge CLK);
            #1 RX_IN = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit pen, input bit ptyp,
                              input bit parbit, input bit stopv, input bit glitch,
                              input bit scramble, input int stop_len, output int sc);
        logic fb[12];
        int   nbits;
        int   len;
        logic v;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1 + i] = d[i];
        nbits = 9;
        if (pen) begin
            fb[nbits] = parbit;
            nbits++;
        end
        fb[nbits] = stopv;
        nbits++;
        sc = 0;
        for (int b = 0; b < nbits; b++) begin
            len = (b == nbits - 1) ? stop_len : p;
            for (int e = 0; e < len; e++) begin
                @(posedge CLK);
                #1;
                if (b == 0 && e == 0) begin
                    PRESCALE = 6'(p);
                    PAR_EN   = pen;
                    PAR_TYP  = ptyp;
                    sc       = cyc;
                end else if (scramble && b == 1 && e == 0) begin
                    PRESCALE = 6'($urandom_range(4, 16) * 2);
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                end
                v = fb[b];
                if (glitch && b >= 1 && b <= 8 && e == p / 2) v = ~v;
                if (b == nbits - 1 && !stopv && e > p / 2 + 1) v = 1'b1;
                RX_IN = v;
            end
        end
    endtask

    task automatic check_frame(input string name, input int sc, input logic [7:0] d, input exp_t m);
        ev_t        ev;
        logic [7:0] exp_data;
        @(negedge CLK);
        #1;
        exp_data = m.dv ? d : last_good;
        check({name, " pulse count"}, evq.size(), 1);
        if (evq.size() > 0) begin
            ev = evq[0];
            check({name, " pulse cycle"}, ev.cyc - sc, m.rel);
            check({name, " DATA_VALID"}, ev.dv, m.dv);
            check({name, " PAR_ERR"}, ev.pe, m.pe);
            check({name, " STP_ERR"}, ev.se, m.se);
            check({name, " P_DATA"}, ev.data, exp_data);
        end
        if (m.dv) last_good = d;
        evq.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " P_DATA"}, P_DATA, 0);
        check({name, " DATA_VALID"}, DATA_VALID, 0);
        check({name, " PAR_ERR"}, PAR_ERR, 0);
        check({name, " STP_ERR"}, STP_ERR, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        exp_t m;
        int   sc;
        bit   parbit;

        vt[0] = '{8'hA5,  8, 0, 0, 0, 1, 0, 1, 0, 0,  78};
        vt[1] = '{8'h3C, 16, 1, 0, 0, 1, 0, 1, 0, 0, 170};
        vt[2] = '{8'h3C, 16, 1, 0, 1, 1, 0, 0, 1, 0, 170};
        vt[3] = '{8'h01,  8, 1, 1, 0, 0, 0, 0, 0, 1,  86};
        vt[4] = '{8'h96, 16, 0, 0, 0, 1, 1, 1, 0, 0, 154};
        vt[5] = '{8'h5A,  8, 1, 0, 1, 0, 0, 0, 1, 1,  86};
        vt[6] = '{8'hE7, 32, 1, 1, 0, 1, 0, 1, 0, 0, 338};

        RST      = 1'b0;
        RX_IN    = 1'b1;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_idle_outputs("reset");
        RST = 1'b1;
        drive(1'b1, 4);
        check("reset no pulse", evq.size(), 0);

        // 3-cycle low glitch; a real start in cycle 6 must be accepted
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        drive(1'b0, 3);
        drive(1'b1, 3);
        check("glitch no pulse", evq.size(), 0);
        send_frame(8'h55, 8, 0, 0, 0, 1, 0, 0, 8, sc);
        check_frame("after glitch", sc, 8'h55, '{1, 0, 0, 78});
        drive(1'b1, 3);

        for (int i = 0; i < 7; i++) begin
            parbit = good_parity(vt[i].d, vt[i].ptyp) ^ vt[i].badpar;
            send_frame(vt[i].d, vt[i].p, vt[i].pen, vt[i].ptyp, parbit, vt[i].stopv,
                       vt[i].glitch, 0, vt[i].p, sc);
            check_frame($sformatf("vec%0d", i), sc, vt[i].d,
                        '{vt[i].dv, vt[i].pe, vt[i].se, vt[i].rel});
            drive(1'b1, 2);
        end

        // Back-to-back, then reset during a third frame
        send_frame(8'h11, 8, 0, 0, 0, 1, 0, 0, 8, sc);
        check_frame("b2b 0x11", sc, 8'h11, '{1, 0, 0, 78});
        send_frame(8'h22, 8, 0, 0, 0, 1, 0, 0, 8, sc);
        check_frame("b2b 0x22", sc, 8'h22, '{1, 0, 0, 78});
        drive(1'b0, 8);
        drive(1'b1, 16);
        drive(1'b0, 5);
        @(posedge CLK);
        #3 RST = 1'b0;
        #1;
        check_idle_outputs("mid-frame reset");
        RX_IN = 1'b1;
        drive(1'b1, 3);
        RST = 1'b1;
        last_good = 8'h00;
        drive(1'b1, 100);
        check("aborted frame no pulse", evq.size(), 0);
        check_idle_outputs("after reset release");

        // Start edge one cycle after the result pulse
        send_frame(8'hC3, 8, 0, 0, 0, 1, 0, 0, 7, sc);
        check_frame("short stop", sc, 8'hC3, '{1, 0, 0, 78});
        send_frame(8'h3A, 8, 1, 1, good_parity(8'h3A, 1), 1, 0, 0, 8, sc);
        check_frame("start after pulse", sc, 8'h3A, '{1, 0, 0, 86});

        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            int         p;
            bit         pen;
            bit         ptyp;
            bit         stopv;
            int         slen;
            d      = 8'($urandom);
            p      = 2 * $urandom_range(4, 16);
            pen    = 1'($urandom);
            ptyp   = 1'($urandom);
            stopv  = ($urandom_range(0, 4) != 0);
            parbit = good_parity(d, ptyp) ^ ($urandom_range(0, 3) == 0);
            slen   = (stopv && $urandom_range(0, 1) == 1) ? p / 2 + 3 : p;
            m      = model(d, p, pen, ptyp, parbit, stopv);
            send_frame(d, p, pen, ptyp, parbit, stopv, 1'($urandom), 1'($urandom), slen, sc);
            check_frame($sformatf("rand%0d", i), sc, d, m);
        end

        drive(1'b1, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the UART block, the counterpart of the UART transmit path. It oversamples RX_IN at PRESCALE clock cycles per bit and decides each bit by a three-sample majority vote. It deserializes an LSB-first frame (start, DATA_WIDTH data bits, optional parity, stop), checks the parity and stop bits, and presents the parallel byte with a one-cycle valid pulse. It sits between the RX pin synchronizer and the system-side consumer.

## Interface
- DATA_WIDTH, 8: number of data bits per frame.
- CLK  in  1  receiver oversampling clock.
- RST  in  1  reset, asynchronous, active-low.
- RX_IN  in  1  serial line, already synchronized to CLK; idle high.
- PRESCALE  in  6  clock cycles per bit; legal values are even numbers 8..32; captured at start detection.
- PAR_EN  in  1  1 means the frame carries a parity bit; captured at start detection.
- PAR_TYP  in  1  0 selects even parity, 1 selects odd; captured at start detection.
- P_DATA  out  DATA_WIDTH  received byte; updated only on a good frame.
- DATA_VALID  out  1  one-cycle pulse when a frame is error-free.
- PAR_ERR  out  1  one-cycle pulse when the parity bit mismatches.
- STP_ERR  out  1  one-cycle pulse when the stop bit samples 0.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: wait for RX_IN==0. That cycle is edge 0 of the start bit. Capture PRESCALE, PAR_EN and PAR_TYP, set edge_cnt to 1, and go to START.
- Edge counter: edge_cnt runs 0..PRESCALE-1 within each bit, wraps to 0, and advances bit_cnt.
- Sampling: RX_IN is sampled at edges P/2-1, P/2 and P/2+1, where P is the captured PRESCALE. The bit value is the majority of the 3 samples and is available at edge P/2+2.
- START: if the voted bit is 1, the start is a glitch. Return to IDLE at edge P/2+2 with no output. Otherwise go to DATA at the bit wrap.
- DATA: shift in bits LSB first. After bit DATA_WIDTH-1 wraps, go to PARITY if PAR_EN, else to STOP.
- PARITY: compare the voted bit with the XOR of the data bits (even parity), or its inverse (odd parity). Latch the mismatch. Go to STOP at the wrap.
- STOP: at edge P/2+2, go to IDLE and fire exactly one of the following for one cycle:
  - stop=1 and no parity error: DATA_VALID=1 and P_DATA is loaded.
  - otherwise: PAR_ERR and/or STP_ERR per the failing check. Both may fire together. DATA_VALID stays 0 and P_DATA keeps its old value.
- Reset values: state IDLE, edge_cnt=0, bit_cnt=0, P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0.
- Reset mid-frame aborts the frame with no pulse.
- Changing PRESCALE, PAR_EN or PAR_TYP mid-frame has no effect until the next start.
- PRESCALE values outside the legal set are unsupported; behaviour is not checked.

## Timing
- Cycle 0 is the first IDLE cycle with RX_IN==0. N = 1 + DATA_WIDTH + PAR_EN + 1.
- The result pulse is visible in cycle (N-1)*P + P/2 + 2:
  - P=8, no parity: cycle 78.
  - P=8, with parity: cycle 86.
  - P=16, no parity: cycle 154.
- The FSM is back in IDLE during the second half of the stop bit. A start edge arriving one cycle after the pulse is accepted.
- Outputs are registered; pulses never exceed one cycle.
- A glitch start returns to IDLE in cycle P/2+2.

## Structure
- Shared package uart_pkg holds:
  - the RX state encoding (IDLE=3'b000, START=3'b001, DATA=3'b011, PARITY=3'b010, STOP=3'b110), matching the TX FSM style;
  - parity type constants PAR_EVEN=0 and PAR_ODD=1;
  - the legal PRESCALE constants 8, 16 and 32.
- Sub-module uart_rx_sampler contains the edge/bit counters and the three-sample majority vote. It outputs the voted bit, a sample-valid strobe at edge P/2+2, and a bit-wrap strobe.
- The top level holds the FSM, the shift register, the parity/stop checks and the output registers.

## Test plan
- P=8, PAR_EN=0: send 0xA5 -> DATA_VALID pulses in cycle 78, P_DATA=0xA5, no error pulses.
- P=16, PAR_EN=1, PAR_TYP=0: send 0x3C with parity bit 0 -> DATA_VALID, P_DATA=0x3C. The same frame with parity bit 1 -> PAR_ERR only, P_DATA unchanged.
- P=8, PAR_TYP=1: send 0x01 with stop bit 0 and correct parity 0 -> STP_ERR only, DATA_VALID=0.
- Low glitch of 3 cycles on an idle line at P=8 -> FSM back in IDLE by cycle 6, no pulses. A following valid 0x55 frame is received.
- One single-cycle glitch at the middle sample of every data bit, 0x96 at P=16 -> majority vote recovers 0x96.
- Back-to-back frames 0x11 and 0x22 with no idle gap, then RST asserted mid-way through a third frame -> two DATA_VALID pulses, then all outputs 0 and no pulse for the aborted frame.
